pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage core's pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register, all built from the team's flop primitives.
- Decodes load-use hazards, taken-branch flushes, instruction-fetch not-ready and data-memory wait handshakes into per-stage enable/flush strobes.
- Includes a data-memory watchdog that traps hung accesses.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: turns load-use, branch, fetch and data-memory
// wait conditions into per-stage enable/flush strobes. Optional macro PIPE_PERF_CNT_EN adds stall_cnt.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_br_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  mem_to_err,
  output logic [1:0]            state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_TRAP = 2'b10;

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(MEM_TIMEOUT);
  localparam logic [TO_CNT_W-1:0] CNT_MAX  = '1;

  // Strobe bundle order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] STRB_FREEZE = 7'b000_0000;
  localparam logic [6:0] STRB_FLOW   = 7'b110_1011;
  localparam logic [6:0] STRB_BRANCH = 7'b111_1111;
  localparam logic [6:0] STRB_BUBBLE = 7'b000_1111;
  localparam logic [6:0] STRB_FETCH  = 7'b011_1011;
  localparam logic [6:0] STRB_HOLD   = 7'b001_0100;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [TO_CNT_W-1:0] to_cnt_next;
  logic [TO_CNT_W-1:0] to_cnt_inc;
  logic                err_next;
  logic                load_use;
  logic                mem_stall;
  logic [6:0]          run_strb;
  logic [6:0]          fsm_strb;
  logic [6:0]          strb;

  // Data-memory handshake: the MEM stage holds dmem_req until a cycle with
  // dmem_ack=1; that ack cycle completes the access and the pipe may advance.
  assign mem_stall = dmem_req && !dmem_ack;

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Pipeline-flow rules shared by RUN and the ack cycle of MEM_WAIT.
  always_comb begin
    run_strb = STRB_FLOW;
    if (ex_br_taken) begin
      run_strb = STRB_BRANCH;
    end else if (load_use) begin
      run_strb = STRB_BUBBLE;
    end else if (!imem_ready) begin
      run_strb = STRB_FETCH;
    end
  end

  always_comb begin
    state_next  = state;
    to_cnt_next = to_cnt;
    err_next    = mem_to_err;
    fsm_strb    = STRB_HOLD;
    to_cnt_inc  = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + TO_CNT_W'(1);
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          fsm_strb    = STRB_FREEZE;
          state_next  = ST_WAIT;
          to_cnt_next = TO_CNT_W'(1);
        end else begin
          fsm_strb = run_strb;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          // A late ack wins even on the cycle the watchdog would have fired.
          fsm_strb    = run_strb;
          state_next  = ST_RUN;
          to_cnt_next = '0;
        end else begin
          fsm_strb    = STRB_FREEZE;
          to_cnt_next = to_cnt_inc;
          if (to_cnt_inc >= TO_LIMIT) begin
            state_next = ST_TRAP;
            err_next   = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        fsm_strb = STRB_HOLD;
      end
      default: begin
        fsm_strb   = STRB_HOLD;
        state_next = ST_RUN;
      end
    endcase
  end

  assign strb = rst ? fsm_strb : STRB_HOLD;

  assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en} = strb;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      to_cnt     <= '0;
      mem_to_err <= 1'b0;
    end else begin
      state      <= state_next;
      to_cnt     <= to_cnt_next;
      mem_to_err <= err_next;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counts frozen-PC cycles; a trapped core is not stalling, it is dead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state != ST_TRAP)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed steps plus randomized traffic checked
// against a cycle-level behavioural model built from the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int REG_ADDR_W  = 5;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [6:0] V_RESET  = 7'b0010100;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_FLOW   = 7'b1101011;
  localparam logic [6:0] V_BRANCH = 7'b1111111;
  localparam logic [6:0] V_BUBBLE = 7'b0001111;
  localparam logic [6:0] V_FETCH  = 7'b0111011;

  logic clk = 1'b0;
  logic rst;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, imem_ready, dmem_req, dmem_ack;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_to_err;
  logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_W (REG_ADDR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_br_taken(ex_br_taken),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_en    (idex_en),
    .idex_flush (idex_flush),
    .exmem_en   (exmem_en),
    .memwb_en   (memwb_en),
    .mem_to_err (mem_to_err),
    .state_o    (state_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  logic [6:0] obs_vec;
  assign obs_vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

  int total = 0;
  int bad = 0;

  // Model: how many consecutive cycles the pending access has gone unacked,
  // whether the watchdog has fired, and how many stalled cycles occurred.
  int          unacked;
  bit          trapped;
  logic [31:0] stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] flow_rules();
    logic hazard;
    hazard = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (ex_br_taken) return V_BRANCH;
    if (hazard)      return V_BUBBLE;
    if (!imem_ready) return V_FETCH;
    return V_FLOW;
  endfunction

  function automatic logic [6:0] expected_vec();
    if (!rst || trapped) return V_RESET;
    if (!dmem_ack && (unacked > 0 || dmem_req)) return V_FREEZE;
    return flow_rules();
  endfunction

  function automatic logic [1:0] expected_state();
    if (trapped) return 2'b10;
    if (unacked > 0) return 2'b01;
    return 2'b00;
  endfunction

  // Inputs are already applied (just after a falling edge); check, then clock.
  task automatic tick();
    logic [6:0] ev;
    if (!rst) begin
      unacked = 0;
      trapped = 0;
      stalls  = 0;
    end
    #1;
    ev = expected_vec();
    chk("strobes", 32'(obs_vec), 32'(ev));
    chk("state", 32'(state_o), 32'(expected_state()));
    chk("mem_to_err", 32'(mem_to_err), 32'(trapped));
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
    @(posedge clk);
    if (rst && !trapped) begin
      if (!ev[6]) stalls = stalls + 32'd1;
      if (unacked == 0) begin
        if (dmem_req && !dmem_ack) unacked = 1;
      end else if (dmem_ack) begin
        unacked = 0;
      end else begin
        unacked++;
        if (unacked >= MEM_TIMEOUT) trapped = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_rs1      = REG_ADDR_W'($urandom_range(1, 31));
    id_rs2      = REG_ADDR_W'($urandom_range(1, 31));
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd       = REG_ADDR_W'($urandom_range(0, 31));
    ex_br_taken = 1'b0;
    imem_ready  = 1'b1;
    dmem_req    = 1'b0;
    dmem_ack    = 1'b0;
  endtask

  task automatic set_random(input int ack_pct);
    id_rs1      = REG_ADDR_W'($urandom_range(0, 3));
    id_rs2      = REG_ADDR_W'($urandom_range(0, 3));
    id_use_rs1  = 1'($urandom_range(0, 1));
    id_use_rs2  = 1'($urandom_range(0, 1));
    ex_is_load  = 1'($urandom_range(0, 1));
    ex_rd       = REG_ADDR_W'($urandom_range(0, 3));
    ex_br_taken = ($urandom_range(0, 5) == 0);
    imem_ready  = ($urandom_range(0, 3) != 0);
    dmem_req    = ($urandom_range(0, 2) == 0);
    dmem_ack    = ($urandom_range(0, 99) < ack_pct);
  endtask

  task automatic set_load_use();
    set_idle();
    ex_is_load = 1'b1;
    ex_rd      = 5'd5;
    id_rs2     = 5'd5;
    id_use_rs2 = 1'b1;
    id_rs1     = 5'd9;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_random(50);
    tick();
    rst = 1'b1;
    set_idle();
  endtask

  initial begin
    unacked = 0;
    trapped = 0;
    stalls  = 0;
    rst = 1'b1;
    set_idle();
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset held for three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      set_random(50);
      tick();
      chk("reset_strobes", 32'(obs_vec), 32'(V_RESET));
      chk("reset_state", 32'(state_o), 32'd0);
    end
    rst = 1'b1;
    set_idle();
    #1 chk("release_flow", 32'(obs_vec), 32'(V_FLOW));
    tick();

    // Load-use: exactly one bubble, then the hazard has moved on.
    set_load_use();
    #1 chk("load_use_bubble", 32'(obs_vec), 32'(V_BUBBLE));
    tick();
    set_idle();
    #1 chk("after_bubble", 32'(obs_vec), 32'(V_FLOW));
    tick();

    // Load to x0 is never a hazard.
    set_load_use();
    ex_rd  = 5'd0;
    id_rs2 = 5'd0;
    #1 chk("x0_no_stall", 32'(pc_en), 32'd1);
    tick();

    // Branch beats a simultaneous load-use hazard and fetch stall.
    set_load_use();
    ex_br_taken = 1'b1;
    imem_ready  = 1'b0;
    #1 chk("branch_over_hazard", 32'(obs_vec), 32'(V_BRANCH));
    tick();

    // Fetch not ready.
    set_idle();
    imem_ready = 1'b0;
    #1 chk("imem_stall", 32'(obs_vec), 32'(V_FETCH));
    tick();

    // Memory wait: four unacked cycles, then the ack cycle flows.
    set_idle();
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_state", 32'(state_o), 32'd1);
    end
    dmem_ack = 1'b1;
    #1 chk("ack_flow", 32'(obs_vec), 32'(V_FLOW));
    tick();
    chk("back_to_run", 32'(state_o), 32'd0);
    set_idle();
    tick();

    // Branch held across a wait is honoured in the ack cycle.
    dmem_req    = 1'b1;
    ex_br_taken = 1'b1;
    tick();
    tick();
    dmem_ack = 1'b1;
    #1 chk("branch_at_ack", 32'(obs_vec), 32'(V_BRANCH));
    tick();
    set_idle();
    tick();

    // Watchdog: sixteen unacked cycles trap, held until reset.
    dmem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) tick();
    chk("trap_state", 32'(state_o), 32'd2);
    chk("trap_err", 32'(mem_to_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_random(80);
      tick();
    end
    chk("trap_held", 32'(state_o), 32'd2);
    do_reset();
    chk("trap_cleared", 32'(mem_to_err), 32'd0);

    // Ack on the sixteenth cycle beats the watchdog.
    dmem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
    dmem_ack = 1'b1;
    tick();
    chk("late_ack_run", 32'(state_o), 32'd0);
    chk("late_ack_no_err", 32'(mem_to_err), 32'd0);
    set_idle();
    tick();

    // Async reset in the middle of a wait.
    dmem_req = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("async_reset_state", 32'(state_o), 32'd0);
    rst = 1'b1;
    set_idle();
    tick();

`ifdef PIPE_PERF_CNT_EN
    // One load-use bubble plus four wait cycles.
    do_reset();
    set_load_use();
    tick();
    set_idle();
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dmem_ack = 1'b1;
    tick();
    set_idle();
    tick();
    chk("perf_stall_cnt", stall_cnt, 32'd5);
`endif

    // Randomized traffic with occasional hung-memory phases and resets.
    for (int i = 0; i < 800; i++) begin
      set_random((((i / 50) % 4) == 3) ? 3 : 50);
      rst = ($urandom_range(0, 59) != 0);
      tick();
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
